serial_pattern_tx: RTL and testbench

Parallel-to-serial bit-stream transmitter that drives the single-bit `a` input of the team's "01" pattern-detector FSM. It accepts a WIDTH-bit word on a start/ready handshake and shifts it out MSB first, one bit per `en` strobe, sharing the detector's `en` step. It also keeps a running count of 0→1 transitions it has emitted, which is the number of detections the downstream detector must report. Benches and lab top levels use this count as the scoreboard reference.

---
 rtl/serial_pattern_tx.sv | 100 ++++++++++
 tb/tb_serial_pattern_tx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx.sv
// MSB-first serial transmitter feeding the "01" pattern detector; counts the
// 0->1 transitions it emits so that count can serve as the detector reference.
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic             pat_clr,
  output logic             ready,
  output logic             a,
  output logic             done,
  output logic [CNT_W-1:0] pat_cnt
);

  localparam int BC_W = $clog2(WIDTH + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_shreg, w_shreg_next;
  logic [BC_W-1:0]  r_bit_cnt, w_bit_cnt_next;
  logic             r_a, w_a_next;
  logic             r_done, w_done_next;
  logic [CNT_W-1:0] r_pat_cnt, w_pat_cnt_next;
  logic             w_shift;

  assign w_shift = (r_state == ST_SHIFT) && en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_a       <= 1'b1;
      r_done    <= 1'b0;
      r_pat_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_shreg   <= w_shreg_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_a       <= w_a_next;
      r_done    <= w_done_next;
      r_pat_cnt <= w_pat_cnt_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_shreg_next   = r_shreg;
    w_bit_cnt_next = r_bit_cnt;
    w_a_next       = r_a;
    w_done_next    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // The accepting edge only loads; the first bit goes out on the next en edge.
        if (start) begin
          w_shreg_next   = data;
          w_bit_cnt_next = BC_W'(WIDTH);
          w_state_next   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (en) begin
          w_a_next       = r_shreg[WIDTH-1];
          w_shreg_next   = {r_shreg[WIDTH-2:0], 1'b0};
          w_bit_cnt_next = r_bit_cnt - BC_W'(1);
          if (r_bit_cnt == BC_W'(1)) begin
            w_done_next  = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Clear has priority over a same-edge increment; the count saturates.
  always_comb begin
    w_pat_cnt_next = r_pat_cnt;
    if (pat_clr) begin
      w_pat_cnt_next = '0;
    end else if (w_shift && r_shreg[WIDTH-1] && !r_a && (r_pat_cnt != {CNT_W{1'b1}})) begin
      w_pat_cnt_next = r_pat_cnt + CNT_W'(1);
    end
  end

  assign ready   = (r_state == ST_IDLE);
  assign a       = r_a;
  assign done    = r_done;
  assign pat_cnt = r_pat_cnt;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench for serial_pattern_tx: directed words are queued with
// hand-computed transition counts and a monitor checks every emitted bit.
module tb_serial_pattern_tx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         en = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] data = '0;
  logic         pat_clr = 1'b0;

  logic         ready, a, done;
  logic [7:0]   pat_cnt;
  logic         aux_ready, aux_a, aux_done;
  logic [1:0]   aux_cnt;

  typedef struct {
    logic [W-1:0] data;
    int           exp_cnt;
    int           exp_aux;
  } word_t;

  word_t q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    rst_events = 0;
  bit    gate_mode = 1'b0;

  serial_pattern_tx #(.WIDTH(W), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .start(start), .data(data),
    .pat_clr(pat_clr), .ready(ready), .a(a), .done(done), .pat_cnt(pat_cnt)
  );

  serial_pattern_tx #(.WIDTH(W), .CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .en(en), .start(start), .data(data),
    .pat_clr(pat_clr), .ready(aux_ready), .a(aux_a), .done(aux_done), .pat_cnt(aux_cnt)
  );

  initial forever #5 clk = ~clk;

  // Shift strobe: free-running or alternating, changed well away from the edge.
  initial forever begin
    @(posedge clk);
    #2;
    en = gate_mode ? ~en : 1'b1;
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: a bit is due on any edge that sees SHIFT (ready=0) with en=1.
  initial begin
    int    idx = 0;
    int    rst_seen = 0;
    bit    shift_now;
    logic  last_a = 1'b1;
    logic  exp_bit;
    word_t w;
    forever begin
      @(negedge clk);
      shift_now = reset_n && !ready && en;
      @(posedge clk);
      #1;
      if (rst_seen != rst_events) begin
        q.delete();
        idx = 0;
        rst_seen = rst_events;
      end else if (shift_now) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_shift: got a=%0b with no word queued, required none at %0t", a, $time);
        end else begin
          w = q[0];
          exp_bit = w.data[W-1-idx];
          check($sformatf("a_bit%0d_%h", idx, w.data), a, exp_bit);
          check("aux_a", aux_a, exp_bit);
          check("done", done, (idx == W-1));
          check("aux_done", aux_done, (idx == W-1));
          if (idx == W-1) begin
            check($sformatf("pat_cnt_%h", w.data), pat_cnt, w.exp_cnt);
            check($sformatf("aux_cnt_%h", w.data), aux_cnt, w.exp_aux);
            $display("word %h sent: pat_cnt=%0d (exp %0d) aux_cnt=%0d (exp %0d)",
                     w.data, pat_cnt, w.exp_cnt, aux_cnt, w.exp_aux);
            void'(q.pop_front());
            idx = 0;
          end else begin
            idx++;
          end
        end
      end else begin
        check("a_hold", a, last_a);
        check("done_idle", done, 1'b0);
      end
      last_a = a;
    end
  end

  // All stimulus tasks start and end at posedge+2.
  task automatic send(input logic [W-1:0] d, input int ec, input int ea);
    int t = 0;
    while (!ready && t < 200) begin
      @(posedge clk);
      #2;
      t++;
    end
    if (!ready) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: got ready=0 after %0d cycles, required 1", t);
    end else begin
      start = 1'b1;
      data  = d;
      q.push_back('{d, ec, ea});
      @(posedge clk);
      #2;
      start = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || !ready) && t < 300) begin
      @(posedge clk);
      #2;
      t++;
    end
    if (q.size() != 0 || !ready) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d words pending, required 0", q.size());
    end
  endtask

  task automatic clear_cnt();
    pat_clr = 1'b1;
    @(posedge clk);
    #2;
    pat_clr = 1'b0;
    check("clr_cnt", pat_cnt, 0);
    check("clr_aux", aux_cnt, 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    rst_events++;
    #1;
    check("rst_a", a, 1'b1);
    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_cnt", pat_cnt, 0);
    check("rst_aux_ready", aux_ready, 1'b1);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #12;
    reset_n = 1'b1;
    @(posedge clk);
    #2;
    check("init_a", a, 1'b1);
    check("init_ready", ready, 1'b1);
    check("init_cnt", pat_cnt, 0);

    // Free-running single word: 0,1,0,1,0,0,1,1 -> 3 transitions.
    send(8'b0101_0011, 3, 3);
    drain();

    // Gated en, same word from a=1.
    clear_cnt();
    gate_mode = 1'b1;
    send(8'b0101_0011, 3, 3);
    drain();
    gate_mode = 1'b0;
    @(posedge clk);
    #2;

    // Back-to-back, start issued in each done cycle.
    clear_cnt();
    send(8'h00, 0, 0);
    send(8'hFF, 1, 1);
    send(8'hFF, 1, 1);
    send(8'h55, 5, 3);

    // Start while busy: AA must be ignored.
    send(8'h3C, 6, 3);
    repeat (2) begin
      @(posedge clk);
      #2;
    end
    check("busy_ready", ready, 1'b0);
    start = 1'b1;
    data  = 8'hAA;
    @(posedge clk);
    #2;
    start = 1'b0;
    data  = '0;
    drain();

    // Reset mid-word, then a clean word from the MSB.
    send(8'h0F, 99, 99);
    repeat (3) begin
      @(posedge clk);
      #2;
    end
    check("mid_a_before_rst", a, 1'b0);
    pulse_reset();
    send(8'h81, 1, 1);
    drain();

    // Saturation of the 2-bit counter.
    pulse_reset();
    send(8'h55, 4, 3);
    send(8'h55, 8, 3);
    drain();

    // Clear on the same edge as an increment (second bit of 0x40).
    pulse_reset();
    send(8'h40, 0, 0);
    @(posedge clk);
    #2;
    pat_clr = 1'b1;
    @(posedge clk);
    #2;
    pat_clr = 1'b0;
    check("clr_vs_inc", pat_cnt, 0);
    check("clr_vs_inc_aux", aux_cnt, 0);
    drain();

    repeat (3) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
